// File: rtl/btn_input_ctrl.sv
// btn_input_ctrl: synchronises, debounces and latches push-button/switch lines behind a 4-word I/O window.
// Define BTN_IRQ_EN to build the MASK register and the irq output; otherwise irq is tied low.
module btn_input_ctrl #(
    parameter int WIDTH    = 16,
    parameter int TICK_DIV = 100000,
    parameter int DB_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_raw,
    input  logic             io_we,
    input  logic [1:0]       io_addr,
    input  logic [31:0]      io_wdata,
    output logic [31:0]      io_rdata,
    output logic [WIDTH-1:0] btn_level,
    output logic             irq
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (DB_COUNT > 0) ? $clog2(DB_COUNT + 1) : 1;
    localparam int PW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [TW-1:0]    div_reg;
    logic             tick;
    logic [WIDTH-1:0] stable_reg;
    logic [WIDTH-1:0] stable_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] event_reg;
    logic [WIDTH-1:0] event_clr;
    logic [7:0]       press_cnt_reg;
    logic [PW-1:0]    rise_cnt;
    logic [8:0]       cnt_sum;
    logic [WIDTH-1:0] mask_rd;
    logic             wr_event;
    logic             wr_count;
    logic             unused_wdata;

    assign wr_event     = io_we && (io_addr == 2'd1);
    assign wr_count     = io_we && (io_addr == 2'd3);
    assign unused_wdata = ^io_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    assign tick = (div_reg == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg <= '0;
        end else if (tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + TW'(1);
        end
    end

    // A bit flips on the tick that would bring its disagreement run to DB_COUNT.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
        logic [CW-1:0] cnt_reg;
        logic [CW-1:0] cnt_next;
        logic          flip;

        always_comb begin
            cnt_next = cnt_reg;
            flip     = 1'b0;
            if (tick) begin
                if (sync2_reg[gi] == stable_reg[gi]) begin
                    cnt_next = '0;
                end else if (cnt_reg == CW'(DB_COUNT - 1)) begin
                    cnt_next = '0;
                    flip     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end

        assign stable_next[gi] = stable_reg[gi] ^ flip;
    end

    assign rise      = stable_next & ~stable_reg;
    assign event_clr = wr_event ? io_wdata[WIDTH-1:0] : '0;

    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rise_cnt = rise_cnt + PW'(rise[i]);
        end
    end

    assign cnt_sum = {1'b0, press_cnt_reg} + 9'(rise_cnt);

    // New rising edges are OR-ed in after the clear so a same-edge set survives W1C.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_reg    <= '0;
            event_reg     <= '0;
            press_cnt_reg <= '0;
        end else begin
            stable_reg <= stable_next;
            event_reg  <= (event_reg & ~event_clr) | rise;
            if (wr_count) begin
                press_cnt_reg <= '0;
            end else if (cnt_sum > 9'd255) begin
                press_cnt_reg <= 8'hFF;
            end else begin
                press_cnt_reg <= cnt_sum[7:0];
            end
        end
    end

`ifdef BTN_IRQ_EN
    logic [WIDTH-1:0] mask_reg;
    logic             irq_reg;
    logic             wr_mask;

    assign wr_mask = io_we && (io_addr == 2'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_reg <= '0;
            irq_reg  <= 1'b0;
        end else begin
            if (wr_mask) begin
                mask_reg <= io_wdata[WIDTH-1:0];
            end
            irq_reg <= |(event_reg & mask_reg);
        end
    end

    assign mask_rd = mask_reg;
    assign irq     = irq_reg;
`else
    assign mask_rd = '0;
    assign irq     = 1'b0;
`endif

    always_comb begin
        io_rdata = '0;
        case (io_addr)
            2'd0:    io_rdata[WIDTH-1:0] = stable_reg;
            2'd1:    io_rdata[WIDTH-1:0] = event_reg;
            2'd2:    io_rdata[WIDTH-1:0] = mask_rd;
            default: io_rdata[7:0]       = press_cnt_reg;
        endcase
    end

    assign btn_level = stable_reg;

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Directed bench for btn_input_ctrl (TICK_DIV=4, DB_COUNT=3) with a cycle-level reference model.
module tb_btn_input_ctrl;
    localparam int W  = 16;
    localparam int TD = 4;
    localparam int DB = 3;
`ifdef BTN_IRQ_EN
    localparam logic [31:0] IRQ_ON = 32'd1;
`else
    localparam logic [31:0] IRQ_ON = 32'd0;
`endif

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic [15:0] btn_raw  = '0;
    logic        io_we    = 1'b0;
    logic [1:0]  io_addr  = '0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic [15:0] btn_level;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_input_ctrl #(.WIDTH(W), .TICK_DIV(TD), .DB_COUNT(DB)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .io_we(io_we), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .btn_level(btn_level), .irq(irq)
    );

    // Reference model: edges since reset decide ticks; per-bit run lengths decide acceptance.
    logic [15:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_ev = '0, m_mask = '0;
    int          m_n = 0;
    int          m_run [16] = '{default: 0};
    int          m_cnt = 0;
    logic        m_irq = 1'b0;

    always @(posedge clk or negedge rst) begin : model
        logic [15:0] ns;
        logic [15:0] rises;
        int          nr [16];
        int          sum;
        if (!rst) begin
            m_s1 <= '0; m_s2 <= '0; m_stable <= '0; m_ev <= '0; m_mask <= '0;
            m_n <= 0; m_run <= '{default: 0}; m_cnt <= 0; m_irq <= 1'b0;
        end else begin
            ns    = m_stable;
            rises = '0;
            nr    = m_run;
            if ((m_n % TD) == TD - 1) begin
                for (int i = 0; i < W; i++) begin
                    if (m_s2[i] == m_stable[i]) nr[i] = 0;
                    else begin
                        nr[i] = nr[i] + 1;
                        if (nr[i] == DB) begin
                            nr[i]    = 0;
                            ns[i]    = ~ns[i];
                            rises[i] = ns[i];
                        end
                    end
                end
            end
            m_irq <= |(m_ev & m_mask);
            m_ev  <= ((io_we && io_addr == 2'd1) ? (m_ev & ~io_wdata[15:0]) : m_ev) | rises;
`ifdef BTN_IRQ_EN
            if (io_we && io_addr == 2'd2) m_mask <= io_wdata[15:0];
`endif
            sum = m_cnt + $countones(rises);
            if (sum > 255) sum = 255;
            m_cnt    <= (io_we && io_addr == 2'd3) ? 0 : sum;
            m_run    <= nr;
            m_stable <= ns;
            m_s2     <= m_s1;
            m_s1     <= btn_raw;
            m_n      <= m_n + 1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {16'h0, m_stable};
            2'd1:    return {16'h0, m_ev};
            2'd2:    return {16'h0, m_mask};
            default: return 32'(m_cnt);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            check("cyc_level", 32'(btn_level), 32'(m_stable));
            check("cyc_irq", 32'(irq), 32'(m_irq));
            check("cyc_rdata", io_rdata, exp_rd(io_addr));
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        io_we = 1'b1; io_addr = a; io_wdata = d;
        @(negedge clk);
        io_we = 1'b0;
        $display("write addr=%0d data=%h", a, d);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        io_addr = a;
        @(posedge clk);
        #1;
        $display("read  addr=%0d data=%h (%s)", a, io_rdata, name);
        check(name, io_rdata, exp);
    endtask

    // Waits for btn_level[i]==v, counting edges from the caller's stimulus change.
    task automatic wait_bit(input int i, input logic v, input int budget, input int lo, input string name);
        int k = 0;
        bit found = 1'b0;
        while (!found && k < budget) begin
            @(posedge clk);
            #1;
            k++;
            if (btn_level[i] === v) found = 1'b1;
        end
        checks++;
        if (!(found && k >= lo)) begin
            errors++;
            $display("FAIL %s: bit %0d reached %0d after %0d clk (found=%0d), required %0d..%0d clk",
                     name, i, v, k, found, lo, budget);
        end
    endtask

    task automatic pulse(input int i);
        @(negedge clk); btn_raw[i] = 1'b1;
        wait_bit(i, 1'b1, 16, 1, "pulse_press");
        @(negedge clk); btn_raw[i] = 1'b0;
        wait_bit(i, 1'b0, 16, 1, "pulse_release");
    endtask

    initial begin
        // Reset held with all inputs high.
        rst = 1'b0; btn_raw = 16'hFFFF;
        repeat (50) @(negedge clk);
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        for (int a = 0; a < 4; a++) rd(2'(a), 32'h0, "rst_reg");
        @(negedge clk); btn_raw = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        rd(2'd0, 32'h0, "idle_state");
        rd(2'd1, 32'h0, "idle_event");

        // Clean press and release of bit 0.
        @(negedge clk); btn_raw[0] = 1'b1;
        wait_bit(0, 1'b1, 14, 11, "press_latency");
        rd(2'd1, 32'h0001, "press_event");
        rd(2'd3, 32'h1, "press_count");
        rd(2'd0, 32'h0001, "press_state");
        @(negedge clk); btn_raw[0] = 1'b0;
        wait_bit(0, 1'b0, 14, 11, "release_latency");
        rd(2'd1, 32'h0001, "release_event");
        rd(2'd3, 32'h1, "release_count");
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, 32'h0, "state_ro");
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, 32'h0, "w1c_clear");
        wr(2'd3, 32'h0);
        rd(2'd3, 32'h0, "count_clear");

        // Bounce on bit 3 lasting two ticks.
        @(negedge clk); btn_raw[3] = 1'b1;
        repeat (8) @(negedge clk);
        btn_raw[3] = 1'b0;
        repeat (30) @(negedge clk);
        check("bounce_level", 32'(btn_level), 32'h0);
        rd(2'd1, 32'h0, "bounce_event");
        rd(2'd3, 32'h0, "bounce_count");

        // Interrupt masking.
        wr(2'd2, 32'h0004);
        rd(2'd2, IRQ_ON * 32'h4, "mask_read");
        @(negedge clk); btn_raw[2] = 1'b1;
        wait_bit(2, 1'b1, 16, 1, "irq_press");
        check("irq_same_edge", 32'(irq), 32'h0);
        @(posedge clk); #1;
        check("irq_assert", 32'(irq), IRQ_ON);
        rd(2'd1, 32'h0004, "irq_event");
        wr(2'd1, 32'h0004);
        @(posedge clk); #1;
        check("irq_deassert", 32'(irq), 32'h0);
        @(negedge clk); btn_raw[2] = 1'b0;
        wait_bit(2, 1'b0, 16, 1, "irq_release");
        @(negedge clk); btn_raw[5] = 1'b1;
        wait_bit(5, 1'b1, 16, 1, "unmasked_press");
        repeat (3) @(posedge clk);
        #1;
        check("irq_unmasked", 32'(irq), 32'h0);
        rd(2'd1, 32'h0020, "event_bit5");
        @(negedge clk); btn_raw[5] = 1'b0;
        wait_bit(5, 1'b0, 16, 1, "unmasked_release");
        rd(2'd3, 32'h2, "count_two");
        wr(2'd1, 32'hFFFF);

        // W1C held across the rising edge of bit 1: set must win.
        @(negedge clk); btn_raw[1] = 1'b1; io_we = 1'b1; io_addr = 2'd1; io_wdata = 32'h0002;
        wait_bit(1, 1'b1, 16, 1, "race_press");
        @(negedge clk); io_we = 1'b0;
        $display("write addr=1 data=00000002 (held through rise)");
        rd(2'd1, 32'h0002, "w1c_race");

        // COUNT write held across the rising edge of bit 4: clear must win.
        @(negedge clk); btn_raw[4] = 1'b1; io_we = 1'b1; io_addr = 2'd3; io_wdata = 32'h0;
        wait_bit(4, 1'b1, 16, 1, "cnt_race_press");
        @(negedge clk); io_we = 1'b0;
        $display("write addr=3 data=00000000 (held through rise)");
        rd(2'd3, 32'h0, "count_race");
        rd(2'd1, 32'h0012, "count_race_event");
        @(negedge clk); btn_raw[1] = 1'b0; btn_raw[4] = 1'b0;
        wait_bit(4, 1'b0, 16, 1, "cnt_race_release");

        // Saturation.
        wr(2'd3, 32'h0);
        for (int p = 0; p < 300; p++) begin
            pulse(0);
            if (p == 9) rd(2'd3, 32'd10, "count_ten");
        end
        rd(2'd3, 32'd255, "count_sat");
        wr(2'd3, 32'h1234);
        rd(2'd3, 32'h0, "count_wr_clear");
        wr(2'd1, 32'hFFFF);

        // All lines pressed together.
        @(negedge clk); btn_raw = 16'hFFFF;
        wait_bit(15, 1'b1, 16, 1, "all_press");
        check("all_level", 32'(btn_level), 32'hFFFF);
        rd(2'd3, 32'd16, "count_all");
        rd(2'd1, 32'hFFFF, "event_all");
        check("irq_all", 32'(irq), IRQ_ON);

        // Asynchronous reset between edges, released with inputs idle.
        @(negedge clk); #2; rst = 1'b0; #1;
        check("async_level", 32'(btn_level), 32'h0);
        check("async_irq", 32'(irq), 32'h0);
        check("async_rdata", io_rdata, 32'h0);
        btn_raw = '0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        rd(2'd1, 32'h0, "post_rst_event");
        rd(2'd3, 32'h0, "post_rst_count");
        rd(2'd2, 32'h0, "post_rst_mask");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
